// File: rtl/dz_countdown.sv
// Countdown sequencer: debounced start/pause and clear keys drive a START_VAL..0
// count stepped by a clock prescaler; outputs feed the dot-matrix digit stage.

module dz_key_db #(
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync_d;
    logic          sync_q;
    logic          db_lvl;
    logic          db_lvl_d;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_d   <= 1'b0;
            sync_q   <= 1'b0;
            db_lvl   <= 1'b0;
            db_lvl_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_d   <= key;
            sync_q   <= sync_d;
            db_lvl_d <= db_lvl;
            // A level change is accepted only after DB_CYCLES consecutive mismatches.
            if (sync_q == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_lvl <= sync_q;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_lvl & ~db_lvl_d;
endmodule

module dz_countdown #(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned DB_CYCLES = 20000,
    parameter int unsigned START_VAL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_clr,
    output logic [2:0] num,
    output logic       running,
    output logic       done
);
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]    NUM_INIT   = 3'(START_VAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          start_press;
    logic          clr_press;
    logic          tick;

    dz_key_db #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk  (clk),
        .rst  (rst),
        .key  (key_start),
        .press(start_press)
    );

    dz_key_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk  (clk),
        .rst  (rst),
        .key  (key_clr),
        .press(clr_press)
    );

    assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            num     <= NUM_INIT;
            running <= 1'b0;
            done    <= 1'b0;
            presc   <= '0;
        end else begin
            done <= 1'b0;
            if (clr_press) begin
                state   <= ST_IDLE;
                num     <= NUM_INIT;
                running <= 1'b0;
                presc   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        presc <= '0;
                        if (start_press) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // The RUN edge always advances the prescaler, even when pausing,
                        // so a tick coinciding with a pause press is still applied.
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick && num <= 3'd1) begin
                            num     <= 3'd0;
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            if (tick) begin
                                num <= num - 3'd1;
                            end
                            if (start_press) begin
                                state   <= ST_PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (start_press) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        presc <= '0;
                        num   <= 3'd0;
                        if (start_press) begin
                            num     <= NUM_INIT;
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        num     <= NUM_INIT;
                        running <= 1'b0;
                        presc   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dz_countdown.sv
// Bench for dz_countdown: elapsed-time reference model checked every cycle,
// plus directed key sequences with hand-computed literal expectations.

module tb_dz_countdown;
    localparam int TICK = 4;
    localparam int DB   = 3;
    localparam int SV   = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_clr;
    logic [2:0] num;
    logic       running;
    logic       done;

    int checks;
    int errors;

    dz_countdown #(
        .TICK_DIV (TICK),
        .DB_CYCLES(DB),
        .START_VAL(SV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_start(key_start),
        .key_clr  (key_clr),
        .num      (num),
        .running  (running),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: keys as sliding windows of synchronized samples,
    // count as elapsed RUN cycles since the last load.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    bit m_lvl_d [2];
    bit m_hist [2][DB];
    int m_since [2];
    int m_mode;
    int m_elapsed;
    bit m_done;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        bit sp;
        bit cp;
        bit raw;
        bit all_diff;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_lvl_d[k] = 0; m_since[k] = 0;
                for (int j = 0; j < DB; j++) m_hist[k][j] = 0;
            end
            m_mode = M_IDLE; m_elapsed = 0; m_done = 0; mvalid = 1'b1;
        end else begin
            sp = m_lvl[0] && !m_lvl_d[0];
            cp = m_lvl[1] && !m_lvl_d[1];
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? key_start : key_clr;
                m_lvl_d[k] = m_lvl[k];
                for (int j = 0; j < DB - 1; j++) m_hist[k][j] = m_hist[k][j+1];
                m_hist[k][DB-1] = m_s2[k];
                if (m_since[k] < DB) m_since[k]++;
                all_diff = 1;
                for (int j = 0; j < DB; j++) if (m_hist[k][j] == m_lvl[k]) all_diff = 0;
                if (m_since[k] >= DB && all_diff) begin
                    m_lvl[k] = !m_lvl[k];
                    m_since[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw;
            end
            m_done = 0;
            if (cp) begin
                m_mode = M_IDLE; m_elapsed = 0;
            end else begin
                case (m_mode)
                    M_IDLE:  if (sp) begin m_mode = M_RUN; m_elapsed = 0; end
                    M_RUN: begin
                        m_elapsed++;
                        if (m_elapsed == SV * TICK) begin m_mode = M_DONE; m_done = 1; end
                        else if (sp) m_mode = M_PAUSE;
                    end
                    M_PAUSE: if (sp) m_mode = M_RUN;
                    default: if (sp) begin m_mode = M_RUN; m_elapsed = 0; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("num_model", int'(num), SV - m_elapsed / TICK);
            chk("running_model", int'(running), (m_mode == M_RUN) ? 1 : 0);
            chk("done_model", int'(done), int'(m_done));
        end
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; key_start = 1'b0; key_clr = 1'b0;
        step(2);
        chk("reset_num", int'(num), 5);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        step(20);
        chk("idle_num", int'(num), 5);
        chk("idle_running", int'(running), 0);

        // Full count
        key_start = 1'b1;
        step(5);
        chk("start_lat_pre", int'(running), 0);
        step(1);
        chk("start_lat", int'(running), 1);
        chk("start_num", int'(num), 5);
        for (int k = 1; k <= 4; k++) begin
            step(4);
            chk("count_step", int'(num), 5 - k);
        end
        step(4);
        chk("done_num", int'(num), 0);
        chk("done_pulse", int'(done), 1);
        chk("done_running", int'(running), 0);
        step(1);
        chk("done_one_cycle", int'(done), 0);
        key_start = 1'b0;
        step(40);
        chk("done_hold", int'(num), 0);

        // Restart from DONE
        key_start = 1'b1;
        step(5);
        chk("restart_pre", int'(num), 0);
        step(1);
        chk("restart_num", int'(num), 5);
        chk("restart_running", int'(running), 1);
        key_start = 1'b0;
        step(10);
        chk("restart_count", int'(num), 3);
        key_clr = 1'b1; step(3); key_clr = 1'b0; step(3);
        chk("clr_num", int'(num), 5);
        chk("clr_running", int'(running), 0);
        step(10);

        // Debounce: short pulses ignored, then a 3-cycle press accepted
        key_start = 1'b1; step(2); key_start = 1'b0; step(5);
        key_start = 1'b1; step(2); key_start = 1'b0;
        step(15);
        chk("glitch_running", int'(running), 0);
        chk("glitch_num", int'(num), 5);
        key_start = 1'b1; step(3); key_start = 1'b0; step(3);
        chk("short_press_run", int'(running), 1);

        // Pause at num=3, prescaler=1, then resume
        step(4);
        key_start = 1'b1;
        step(6);
        chk("pause_running", int'(running), 0);
        chk("pause_num", int'(num), 3);
        key_start = 1'b0;
        step(30);
        chk("pause_hold", int'(num), 3);
        chk("pause_hold_run", int'(running), 0);
        key_start = 1'b1; step(3); key_start = 1'b0; step(3);
        chk("resume_running", int'(running), 1);
        chk("resume_num", int'(num), 3);
        step(1);
        chk("resume_plus1", int'(num), 3);
        step(1);
        chk("resume_plus2", int'(num), 2);
        step(10);
        key_clr = 1'b1; step(3); key_clr = 1'b0; step(3);
        chk("clr2_running", int'(running), 0);
        step(10);

        // Clear and start together at num=2
        key_start = 1'b1; step(3); key_start = 1'b0; step(3);
        step(8);
        key_start = 1'b1; key_clr = 1'b1;
        step(5);
        chk("prio_pre_num", int'(num), 2);
        chk("prio_pre_run", int'(running), 1);
        step(1);
        chk("prio_num", int'(num), 5);
        chk("prio_running", int'(running), 0);
        chk("prio_done", int'(done), 0);
        key_start = 1'b0; key_clr = 1'b0;
        step(40);
        chk("prio_idle", int'(running), 0);

        // Reset mid-run with a key mid-debounce
        key_start = 1'b1; step(3); key_start = 1'b0; step(3);
        chk("run3", int'(running), 1);
        step(6);
        key_start = 1'b1;
        step(2);
        chk("prerst_num", int'(num), 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_num", int'(num), 5);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        step(5);
        chk("requal_pre", int'(running), 0);
        step(1);
        chk("requal", int'(running), 1);
        key_start = 1'b0;
        step(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dz_countdown.md
Name: dz_countdown

Overview:
Countdown sequencer that drives the 3-bit digit input of the dot-matrix display stage.
- Debounces two raw push-buttons: start/pause and clear.
- Divides the system clock into a 1-step tick.
- Counts START_VAL down to 0 under a small state machine.
- Presents the current digit, a running flag and a one-cycle done pulse.

Parameters:
TICK_DIV, 1000000, clock cycles per count step (>=2)
DB_CYCLES, 20000, consecutive stable synchronized cycles needed to accept a key level change (>=1)
START_VAL, 5, value loaded on reset/clear/restart (1..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
key_start  input  1  raw start/pause button, active-high, asynchronous to clk
key_clr  input  1  raw clear button, active-high, asynchronous to clk
num  output  3  current digit to display stage (registered)
running  output  1  high while state is RUN (registered)
done  output  1  one-cycle pulse when count reaches 0 (registered)

Behaviour:
- One clock; reset is synchronous and active-high, on ports clk/rst.
- Reset values:
  - state=IDLE, num=START_VAL, running=0, done=0, prescaler=0.
  - Synchronizers and debounced levels=0; debounce counters=0.
- Key path (identical for each key):
  - Synchronizer: 2-flop; sync_q is valid at edge 2 after a raw change.
  - Debounce: db_cnt increments on each edge where sync_q != db_lvl. db_cnt clears on any edge where they match.
  - Acceptance: on the edge where db_cnt==DB_CYCLES-1 and a mismatch persists, db_lvl<=sync_q and db_cnt<=0.
  - press = db_lvl & ~db_lvl_d (db_lvl_d is db_lvl delayed one cycle). One press per accepted rising level; release generates nothing.
  - The FSM acts on press at the edge after db_lvl rises, i.e. edge 3+DB_CYCLES after the raw rise, for a glitch-free key.
  - A raw glitch shorter than DB_CYCLES synchronized cycles produces no press.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds in PAUSE; clears to 0 in IDLE and DONE.
  - tick = (state==RUN && prescaler==TICK_DIV-1); the prescaler wraps to 0 on that edge.
- FSM (clr_press has priority over start_press in every state):
  - IDLE: start_press -> RUN, prescaler=0.
  - RUN, on tick with num>1: num<=num-1.
  - RUN, on tick with num==1: num<=0, state<=DONE, done<=1 for exactly that one cycle.
  - RUN, start_press -> PAUSE, prescaler held. If tick occurs on the same edge, the tick is still applied (num decrements, or DONE is entered and DONE wins over PAUSE).
  - PAUSE: num and prescaler frozen; start_press -> RUN, prescaler resumes from its held value.
  - DONE: num held at 0. start_press -> num<=START_VAL, prescaler=0, state RUN.
  - Any state, clr_press -> IDLE, num=START_VAL, prescaler=0, done=0.
- running=1 exactly in the cycles where registered state==RUN.
- done is low in every cycle other than the DONE-entry cycle.
- num never leaves the range 0..START_VAL and never wraps below 0.
- rst asserted mid-count returns all outputs to reset values on the next edge, including a mid-debounce key, which must be re-qualified.

Test Plan:
(bench params TICK_DIV=4, DB_CYCLES=3, START_VAL=5; keys held stable unless stated)
1. Reset/idle: rst high 2 cycles, then low 20 cycles with no keys -> num=5, running=0, done=0 throughout.
2. Full count: key_start raw high from edge E -> running=1 from edge E+6. num steps 5,4,3,2,1,0 every 4 cycles; done high one cycle exactly when num becomes 0; running=0 after; num stays 0 for 40 further cycles.
3. Debounce: key_start pulsed high 2 cycles, low 5, high 2 -> no state change, num=5, running=0. A 3-cycle stable press -> RUN.
4. Pause/resume: start, then a second press while num=3 with prescaler=1 -> running=0, num=3 held 30 cycles. A third press -> resumes; next decrement occurs 2 cycles after re-entry to RUN.
5. Clear priority: key_start and key_clr rise on the same edge while in RUN at num=2 -> state IDLE, num=5, running=0, no done pulse.
6. Restart/reset mid-run:
   - From DONE, press start -> num=5, running=1, count repeats.
   - rst high for 1 cycle at num=3 -> next edge num=5, running=0, done=0.
